// File: rtl/dot_product_mac_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dot_product_mac_if : start/operand/result bundle of the dot-product MAC     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface dot_product_mac_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] bias;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] w;
   logic             in_valid;
   logic             in_ready;
   logic             busy;
   logic [WIDTH-1:0] sum;
   logic             out_valid;

   modport master (
      output start, bias, x, w, in_valid,
      input  in_ready, busy, sum, out_valid
   );

   modport slave (
      input  start, bias, x, w, in_valid,
      output in_ready, busy, sum, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/dot_product_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dot_product_mac : sequential Q-format MAC, sum = sat(sum(x*w) + bias)       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dot_product_mac #(
   parameter int WIDTH    = 32,
   parameter int FL       = 24,
   parameter int N_INPUTS = 4,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   dot_product_mac_if.slave  mac
);
   localparam int ACC_W = 2*WIDTH - FL;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_INPUTS - 1);
   localparam logic signed [ACC_W:0] C_MAX = {{(ACC_W+1-WIDTH){1'b0}}, 1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W:0] C_MIN = {{(ACC_W+2-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_BIAS = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]        bias_q, bias_d;
   logic [WIDTH-1:0]        sum_q, sum_d;
   logic                    out_valid_q, out_valid_d;

   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]   term;
   logic signed [ACC_W:0]     total;
   logic [WIDTH-1:0]          sat;

   // Arithmetic shift of the full product floors toward minus infinity.
   assign prod  = (2*WIDTH)'($signed(mac.x)) * (2*WIDTH)'($signed(mac.w));
   assign term  = ACC_W'(prod >>> FL);
   assign total = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-WIDTH){bias_q[WIDTH-1]}}, bias_q};

   always_comb begin
      sat = total[WIDTH-1:0];
      if (total > C_MAX) begin
         sat = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (total < C_MIN) begin
         sat = {1'b1, {(WIDTH-1){1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         bias_q      <= '0;
         sum_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         bias_q      <= bias_d;
         sum_q       <= sum_d;
         out_valid_q <= out_valid_d;
      end
   end

   // With en low every next-state equals the current state, freezing the block.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      bias_d      = bias_q;
      sum_d       = sum_q;
      out_valid_d = out_valid_q;
      if (en) begin
         out_valid_d = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (mac.start) begin
                  acc_d   = '0;
                  cnt_d   = '0;
                  bias_d  = mac.bias;
                  state_d = S_ACC;
               end
            end
            S_ACC: begin
               if (mac.in_valid) begin
                  acc_d = acc_q + term;
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == C_LAST) begin
                     state_d = S_BIAS;
                  end
               end
            end
            S_BIAS: begin
               sum_d       = sat;
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign mac.in_ready  = (state_q == S_ACC) && en;
   assign mac.busy      = (state_q != S_IDLE);
   assign mac.sum       = sum_q;
   assign mac.out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_dot_product_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dot_product_mac : scoreboard bench for dot_product_mac                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dot_product_mac;
   localparam int N = 4;

   typedef struct {
      logic [31:0] sum;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic en;

   dot_product_mac_if #(.WIDTH(32)) mac ();

   dot_product_mac #(
      .WIDTH    (32),
      .FL       (24),
      .N_INPUTS (N),
      .CNT_W    (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .mac (mac)
   );

   always #5 clk = ~clk;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   exp_t        q[$];
   exp_t        mon_e;
   bit          pend = 1'b0;
   logic [31:0] last_sum = 32'h0;
   logic [31:0] last_pushed = 32'h0;
   logic [31:0] xs[N];
   logic [31:0] ws[N];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endfunction

   // Reference: exact products floored by 2^24, 40-bit wrapping sum, then clamp.
   function automatic logic [31:0] model(input logic [31:0] b);
      longint acc, p, t;
      logic [31:0] r;
      acc = 0;
      for (int i = 0; i < N; i++) begin
         p   = longint'($signed(xs[i])) * longint'($signed(ws[i]));
         p   = p >>> 24;
         acc = acc + p;
         acc = (acc <<< 24) >>> 24;
      end
      t = acc + longint'($signed(b));
      if (t > 64'sd2147483647)        r = 32'h7FFFFFFF;
      else if (t < -64'sd2147483648)  r = 32'h80000000;
      else                            r = t[31:0];
      return r;
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0:       return r;
         1:       return {{6{r[25]}}, r[25:0]};
         2:       return {{9{r[22]}}, r[22:0]};
         default: return r[0] ? 32'h7FFFFFFF : 32'h80000000;
      endcase
   endfunction

   // Monitor: pops one expectation per enabled out_valid cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            pend = 1'b0;
         end else if (en === 1'b1) begin
            if (pend) begin
               chk("out_valid pulse width", 64'(mac.out_valid), 64'h0);
               pend = 1'b0;
            end
            if (mac.out_valid !== 1'b0) begin
               if (q.size() == 0) begin
                  chk("unexpected out_valid", 64'(mac.out_valid), 64'h0);
               end else begin
                  mon_e = q.pop_front();
                  chk("sum", 64'(mac.sum), 64'(mon_e.sum));
                  chk("out_valid cycle", 64'(cyc), 64'(mon_e.cyc));
                  last_sum = mon_e.sum;
               end
               pend = 1'b1;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic gap_cycle();
      mac.in_valid = 1'b0;
      mac.x        = $urandom;
      mac.w        = $urandom;
      step(1);
   endtask

   task automatic enlow_cycle(input int b);
      en           = 1'b0;
      mac.in_valid = 1'b1;
      mac.x        = xs[b];
      mac.w        = ws[b];
      @(negedge clk);
      chk("in_ready while en low", 64'(mac.in_ready), 64'h0);
      chk("out_valid held", 64'(mac.out_valid), 64'h0);
      chk("sum held", 64'(mac.sum), 64'(last_sum));
      step(1);
      en = 1'b1;
   endtask

   // Returns in the BIAS cycle (or the cycle after an abort).
   task automatic run_op(input logic [31:0] bias, input int gap_beat, input int gap_len,
                         input int enl_beat, input int enl_len, input bit rnd,
                         input int abort_after, input bit start_mid, input int post_hold);
      int   s;
      int   extra;
      int   k;
      exp_t e;
      extra        = 0;
      rst          = 1'b0;
      en           = 1'b1;
      mac.start    = 1'b1;
      mac.bias     = bias;
      mac.in_valid = 1'b1;
      mac.x        = xs[0];
      mac.w        = ws[0];
      s            = cyc;
      step(1);
      mac.start = 1'b0;
      mac.bias  = $urandom;
      for (int b = 0; b < N; b++) begin
         if (b == gap_beat) begin
            for (int g = 0; g < gap_len; g++) begin gap_cycle(); extra++; end
         end
         if (b == enl_beat) begin
            for (int g = 0; g < enl_len; g++) begin enlow_cycle(b); extra++; end
         end
         if (rnd) begin
            k = 0;
            while (($urandom_range(0, 3) == 0) && (k < 8)) begin
               if ($urandom_range(0, 1) == 1) gap_cycle();
               else enlow_cycle(b);
               extra++;
               k++;
            end
         end
         if (start_mid && b == 2) mac.start = 1'b1;
         mac.in_valid = 1'b1;
         mac.x        = xs[b];
         mac.w        = ws[b];
         step(1);
         mac.start = 1'b0;
         if (b + 1 == abort_after) begin
            mac.in_valid = 1'b0;
            rst          = 1'b1;
            step(1);
            rst = 1'b0;
            @(negedge clk);
            chk("abort busy", 64'(mac.busy), 64'h0);
            chk("abort in_ready", 64'(mac.in_ready), 64'h0);
            chk("abort sum", 64'(mac.sum), 64'h0);
            chk("abort out_valid", 64'(mac.out_valid), 64'h0);
            last_sum = 32'h0;
            step(1);
            return;
         end
      end
      mac.in_valid = 1'b0;
      e.sum        = model(bias);
      e.cyc        = s + N + 2 + extra + post_hold;
      last_pushed  = e.sum;
      q.push_back(e);
   endtask

   task automatic set_nominal();
      xs[0] = 32'h01000000; ws[0] = 32'h00800000;
      xs[1] = 32'h02000000; ws[1] = 32'h00800000;
      xs[2] = 32'hFF800000; ws[2] = 32'h01000000;
      xs[3] = 32'h00400000; ws[3] = 32'h04000000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      en           = 1'b0;
      mac.start    = 1'b0;
      mac.bias     = '0;
      mac.x        = '0;
      mac.w        = '0;
      mac.in_valid = 1'b0;

      repeat (2) begin
         en           = 1'($urandom_range(0, 1));
         mac.start    = 1'($urandom_range(0, 1));
         mac.in_valid = 1'($urandom_range(0, 1));
         mac.x        = $urandom;
         mac.w        = $urandom;
         mac.bias     = $urandom;
         step(1);
      end
      @(negedge clk);
      chk("reset sum", 64'(mac.sum), 64'h0);
      chk("reset out_valid", 64'(mac.out_valid), 64'h0);
      chk("reset in_ready", 64'(mac.in_ready), 64'h0);
      chk("reset busy", 64'(mac.busy), 64'h0);
      step(1);
      rst          = 1'b0;
      en           = 1'b1;
      mac.start    = 1'b0;
      mac.in_valid = 1'b0;
      step(1);
      @(negedge clk);
      chk("idle after reset busy", 64'(mac.busy), 64'h0);
      chk("idle after reset in_ready", 64'(mac.in_ready), 64'h0);
      step(1);

      // Nominal 2.5
      set_nominal();
      run_op(32'h00800000, -1, 0, -1, 0, 1'b0, 0, 1'b0, 0);
      step(3);

      // Two idle beats after the first beat, three en-low cycles later on
      run_op(32'h00800000, 1, 2, 2, 3, 1'b0, 0, 1'b0, 0);
      step(3);

      // en dropped across the out_valid cycle: strobe and sum must hold
      run_op(32'h00800000, -1, 0, -1, 0, 1'b0, 0, 1'b0, 2);
      step(1);
      en = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("held out_valid", 64'(mac.out_valid), 64'h1);
         chk("held sum", 64'(mac.sum), 64'(last_pushed));
         step(1);
      end
      en = 1'b1;
      step(3);

      // Saturation and floor
      for (int i = 0; i < N; i++) begin xs[i] = 32'h7F000000; ws[i] = 32'h7F000000; end
      run_op(32'h0, -1, 0, -1, 0, 1'b0, 0, 1'b0, 0);
      step(2);
      for (int i = 0; i < N; i++) begin xs[i] = 32'h81000000; ws[i] = 32'h7F000000; end
      run_op(32'h0, -1, 0, -1, 0, 1'b0, 0, 1'b0, 0);
      step(2);
      for (int i = 0; i < N; i++) begin xs[i] = 32'h0; ws[i] = 32'h0; end
      xs[1] = 32'hFFFFFFFF; ws[1] = 32'h00800000;
      run_op(32'h0, -1, 0, -1, 0, 1'b0, 0, 1'b0, 0);
      step(2);

      // start during ACC is ignored; then back-to-back start in out_valid cycle
      set_nominal();
      run_op(32'h00800000, -1, 0, -1, 0, 1'b0, 0, 1'b1, 0);
      step(1);
      xs[3] = 32'hFE000000;
      run_op(32'hFF000000, -1, 0, -1, 0, 1'b0, 0, 1'b0, 0);
      step(3);

      // Abort after beat 2, then clean nominal run
      for (int i = 0; i < N; i++) begin xs[i] = 32'h05000000; ws[i] = 32'h03000000; end
      run_op(32'h01000000, -1, 0, -1, 0, 1'b0, 2, 1'b0, 0);
      set_nominal();
      run_op(32'h00800000, -1, 0, -1, 0, 1'b0, 0, 1'b0, 0);
      step(3);

      // Randomized operands, gaps and en stalls
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < N; i++) begin xs[i] = rnd_op(); ws[i] = rnd_op(); end
         run_op(rnd_op(), -1, 0, -1, 0, 1'b1, 0, 1'b0, 0);
         if ($urandom_range(0, 1) == 1) step(1);
         else step($urandom_range(2, 4));
      end

      for (int i = 0; i < 20 && q.size() != 0; i++) step(1);
      step(2);
      chk("results drained", 64'(q.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/dot_product_mac.md
# dot_product_mac

Sequential multiply-accumulate stage that computes one neuron pre-activation, sum = Σ x[i]·w[i] + bias, over N_INPUTS operand pairs in signed Q8.24. It sits directly upstream of the tanh activation unit. Its `sum` drives the activation's `a` input, and it shares the same `clk`/`en`/`rst`. One operand pair is accepted per cycle through a valid/ready handshake. The result leaves through a saturated, registered output with a one-cycle `out_valid` pulse.

## Interface
- WIDTH, 32: data width, signed two's complement.
- FL, 24: fractional bits (Q8.24 default).
- N_INPUTS, 4: operand pairs per dot product, 1..255.
- CNT_W, 8: beat-counter width; must hold N_INPUTS-1.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global clock enable. When low, all state and outputs freeze.
- start  in  1  starts one dot product; sampled only in IDLE with en=1.
- bias  in  WIDTH  bias value, latched on the accepted start.
- x  in  WIDTH  activation operand, signed Q8.24.
- w  in  WIDTH  weight operand, signed Q8.24.
- in_valid  in  1  x/w valid.
- in_ready  out  1  equals (state==ACC) & en; a beat transfers when in_valid & in_ready.
- busy  out  1  high when state is not IDLE.
- sum  out  WIDTH  registered, saturated result.
- out_valid  out  1  registered result strobe.

## Operation
- The FSM has three states.
  - IDLE. On start & en: acc←0, cnt←0, bias_r←bias, go to ACC. start while busy is ignored.
  - ACC. On each beat: acc←acc + (x·w >>> FL) and cnt←cnt+1. On the beat where cnt==N_INPUTS-1, go to BIAS.
  - BIAS. Compute t = acc + sign-extended bias_r. Then sum←sat(t), out_valid←1, go to IDLE.
- Product rules:
  - The full 2·WIDTH signed product is formed.
  - It is arithmetic-shifted right by FL, which is truncation toward −∞.
  - It is kept at ACC_W = 2·WIDTH−FL bits (40 by default).
- Accumulator:
  - The accumulator is ACC_W bits signed and wraps without saturation.
  - Intermediate partial sums may exceed the WIDTH range; only the final value is saturated.
- Saturation:
  - t > 2^(WIDTH−1)−1 gives 0x7FFFFFFF.
  - t < −2^(WIDTH−1) gives 0x80000000.
  - Otherwise sum = t[WIDTH−1:0].
- out_valid is high for exactly one enabled cycle, then clears to 0.
- sum holds its last value until the next result is written.
- en=0 freezes everything:
  - No beat is accepted, because in_ready is low.
  - State, counter and accumulator are held.
  - out_valid and sum hold their current values. The consumer qualifies them with the same en.
- rst=1 has priority over all other inputs. It forces IDLE, and clears acc, cnt, bias_r, sum, out_valid and busy. The reset value of every output is 0.

## Timing
- Cycle 0: start is accepted (IDLE, en=1).
- Cycles 1..: in_ready=1, one beat per cycle while in_valid=1.
- The last beat is in cycle k. BIAS is in cycle k+1. out_valid=1 and sum are valid in cycle k+2.
- With no gaps, out_valid occurs N_INPUTS+2 cycles after start. Each idle or en-low cycle adds one cycle.
- Throughput: a new start is accepted in the cycle where out_valid=1, because the FSM is already in IDLE.
- One operation therefore takes N_INPUTS+2 cycles back-to-back.
- Combined with the downstream activation's 3-register pipeline, the activated output appears 3 cycles after out_valid.
- A beat presented with in_valid=1 while in_ready=0 is not consumed; the source must hold it.

## Test plan
- Reset: rst high for 2 cycles with random inputs → sum=0, out_valid=0, in_ready=0, busy=0. One cycle after rst falls with no start → still IDLE.
- Nominal:
  - Stimulus: N_INPUTS=4, x={0x01000000, 0x02000000, 0xFF800000, 0x00400000}, w={0x00800000, 0x00800000, 0x01000000, 0x04000000}, bias=0x00800000, back-to-back beats.
  - Required response: sum=0x02800000 (2.5), with out_valid exactly 6 cycles after start and lasting 1 cycle.
- Gaps and en stalls:
  - Stimulus: the nominal vectors with in_valid low for 2 cycles after beat 1, plus en low for 3 cycles during ACC.
  - Required response: same 0x02800000; out_valid delayed by 5 cycles. During en low, in_ready=0 and out_valid/sum are held.
- Saturation and truncation:
  - x=w=0x7F000000 ×4, bias=0 → sum=0x7FFFFFFF.
  - x=0x81000000, w=0x7F000000 ×4 → 0x80000000.
  - x=0xFFFFFFFF, w=0x00800000, other pairs 0 → 0xFFFFFFFF (floor).
- Start handling: start pulsed during ACC → ignored, result unchanged. start asserted in the out_valid cycle → the second operation completes N_INPUTS+2 cycles later.
- Reset mid-operation: rst asserted after beat 2 → next cycle IDLE with all outputs 0. A following full nominal run → 0x02800000 with no residue from the aborted run.
